// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer: samples dext every clk edge and shifts it into dout.
// dout_valid pulses for one cycle each time BITS samples have been collected since reset.
module serial_to_parallel #(
  parameter int unsigned BITS      = 10,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dext,
  output logic [BITS-1:0] dout,
  output logic            dout_valid,
  output logic [CW-1:0]   bit_cnt
);

  if (BITS < 2 || BITS > 64) begin : g_bad_width
    $error("serial_to_parallel: BITS must be in 2..64");
  end

  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  logic [BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            valid_q, valid_d;
  logic            wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[BITS-2:0], dext};
    end else begin
      shift_d = {dext, shift_q[BITS-1:1]};
    end
  end

  // Word alignment comes only from reset; the counter free-runs otherwise.
  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    valid_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = shift_q;
  assign dout_valid = valid_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: one MSB-first and one LSB-first instance
// share the same serial stream and reset.
module tb_serial_to_parallel;

  localparam int W  = 10;
  localparam int CW = $clog2(W);

  logic          clk;
  logic          rst_n;
  logic          dext;
  logic [W-1:0]  dout,     dout_l;
  logic          dout_valid, dout_valid_l;
  logic [CW-1:0] bit_cnt,  bit_cnt_l;

  int checks;
  int errors;

  serial_to_parallel #(.BITS(W), .MSB_FIRST(1'b1)) s2p (
    .clk(clk), .rst_n(rst_n), .dext(dext),
    .dout(dout), .dout_valid(dout_valid), .bit_cnt(bit_cnt)
  );

  serial_to_parallel #(.BITS(W), .MSB_FIRST(1'b0)) s2p_lsb (
    .clk(clk), .rst_n(rst_n), .dext(dext),
    .dout(dout_l), .dout_valid(dout_valid_l), .bit_cnt(bit_cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  // Drive one sample, let one rising edge take it, then sit 1 ns past the edge.
  task automatic step(input logic b);
    dext = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dext  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dext  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dext = ~dext;
      @(posedge clk);
      #1;
      checks++;
      if (dout !== '0 || dout_valid !== 1'b0 || bit_cnt !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: dout=%h valid=%b cnt=%0d, want 000/0/0",
                 i, dout, dout_valid, bit_cnt);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++;
    if (dout !== 10'h00F || bit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL pre_async: dout=%h cnt=%0d, want 00f/4", dout, bit_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: dout=%h valid=%b cnt=%0d, want 000/0/0",
               dout, dout_valid, bit_cnt);
    end
  endtask

  task automatic test_basic_word();
    logic [W-1:0] pat;
    pat = 10'b1011001110;
    do_reset();
    for (int i = 0; i < W; i++) begin
      step(pat[W-1-i]);
      if (i == 2) begin
        checks++;
        if (dout !== 10'b0000000101 || bit_cnt !== 4'd3 || dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL live_shift: dout=%h cnt=%0d valid=%b, want 005/3/0",
                   dout, bit_cnt, dout_valid);
        end
      end
      if (i < W - 1) begin
        checks++;
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid edge %0d: valid=%b, want 0", i + 1, dout_valid);
        end
      end
    end
    checks++;
    if (dout !== 10'h2CE || dout_valid !== 1'b1 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL basic_word: dout=%h valid=%b cnt=%0d, want 2ce/1/0",
               dout, dout_valid, bit_cnt);
    end
    step(1'b0);
    checks++;
    if (dout_valid !== 1'b0 || bit_cnt !== 4'd1) begin
      errors++;
      $display("FAIL valid_one_cycle: valid=%b cnt=%0d, want 0/1", dout_valid, bit_cnt);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    for (int k = 1; k <= 3 * W; k++) begin
      logic exp_v;
      logic [CW-1:0] exp_c;
      step(logic'((k - 1) % 2));
      exp_v = (k % W == 0);
      exp_c = CW'(k % W);
      checks++;
      if (dout_valid !== exp_v || bit_cnt !== exp_c) begin
        errors++;
        $display("FAIL stream edge %0d: valid=%b cnt=%0d, want %b/%0d",
                 k, dout_valid, bit_cnt, exp_v, exp_c);
      end
      if (exp_v) begin
        checks++;
        if (dout !== 10'h155) begin
          errors++;
          $display("FAIL stream_word edge %0d: dout=%h, want 155", k, dout);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL partial_valid edge %0d: valid=%b, want 0", i + 1, dout_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: dout=%h cnt=%0d, want 000/0", dout, bit_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= W; i++) begin
      step(1'b1);
      if (i < W) begin
        checks++;
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_valid edge %0d: valid=%b, want 0", i, dout_valid);
        end
      end
    end
    checks++;
    if (dout !== 10'h3FF || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_word: dout=%h valid=%b, want 3ff/1", dout, dout_valid);
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    step(1'b1);
    checks++;
    if (dout_l !== 10'h200 || dout !== 10'h001) begin
      errors++;
      $display("FAIL lsb_entry: lsb=%h msb=%h, want 200/001", dout_l, dout);
    end
    for (int i = 1; i < W; i++) step(1'b0);
    checks++;
    if (dout_l !== 10'h001 || dout_valid_l !== 1'b1 || bit_cnt_l !== '0) begin
      errors++;
      $display("FAIL lsb_word: dout=%h valid=%b cnt=%0d, want 001/1/0",
               dout_l, dout_valid_l, bit_cnt_l);
    end
    checks++;
    if (dout !== 10'h200 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL msb_same_stream: dout=%h valid=%b, want 200/1", dout, dout_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    dext   = 1'b0;
    test_reset();
    test_basic_word();
    test_continuous();
    test_reset_mid_word();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
